// File: rtl/ps2_keyboard_ascii_if.sv
// Host-side FIFO interface of the PS/2 keyboard receiver: pop handshake, head byte and ASCII view.
interface ps2_keyboard_ascii_if;
  logic       nextdata_n;
  logic       uppercase;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic [7:0] ascii;

  modport master (
    input  nextdata_n,
    input  uppercase,
    output data,
    output ready,
    output overflow,
    output ascii
  );

  modport slave (
    output nextdata_n,
    output uppercase,
    input  data,
    input  ready,
    input  overflow,
    input  ascii
  );
endinterface

// File: rtl/ps2_keyboard_ascii.sv
// PS/2 keyboard receiver with 8-entry scan-code FIFO and combinational ASCII translation.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity frame validation.
module ps2_keyboard_ascii (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  ps2_keyboard_ascii_if.master  bus
);

  logic [2:0] clk_sync;
  logic [2:0] data_sync;
  logic       clk_prev;
  logic [3:0] bit_cnt;
  logic [9:0] shreg;
  logic [7:0] mem [8];
  logic [2:0] wr_ptr;
  logic [2:0] rd_ptr;
  logic [3:0] count;
  logic       overflow_q;

  logic       fall;
  logic       bit_in;
  logic       frame_ok;
  logic       push;
  logic       pop;
  logic       full;
  logic       do_write;

  assign fall   = clk_prev & ~clk_sync[2];
  assign bit_in = data_sync[2];

  // On the stop bit, shreg holds {parity, data[7:0], start}.
`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = ~shreg[0] & bit_in & (^shreg[9:1]);
`else
  assign frame_ok = ~shreg[0] & bit_in;
`endif

  assign push     = fall && (bit_cnt == 4'd10) && frame_ok;
  assign pop      = (count != 4'd0) && !bus.nextdata_n;
  assign full     = (count == 4'd8);
  assign do_write = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync   <= 3'b111;
      data_sync  <= 3'b111;
      clk_prev   <= 1'b1;
      bit_cnt    <= 4'd0;
      shreg      <= 10'd0;
      wr_ptr     <= 3'd0;
      rd_ptr     <= 3'd0;
      count      <= 4'd0;
      overflow_q <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[1:0], ps2_data};
      clk_prev  <= clk_sync[2];
      if (fall) begin
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
        end else if (!(bit_cnt == 4'd0 && bit_in)) begin
          // Idle bits while hunting for a start bit are skipped to resync after reset.
          shreg   <= {bit_in, shreg[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
      if (do_write) wr_ptr <= wr_ptr + 3'd1;
      if (pop)      rd_ptr <= rd_ptr + 3'd1;
      unique case ({do_write, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_write) mem[wr_ptr] <= shreg[8:1];
  end

  assign bus.data     = mem[rd_ptr];
  assign bus.ready    = (count != 4'd0);
  assign bus.overflow = overflow_q;

  logic [7:0] letter;
  logic [7:0] symbol;

  always_comb begin
    letter = 8'h00;
    symbol = 8'h00;
    case (bus.data)
      8'h1C: letter = 8'h61;
      8'h32: letter = 8'h62;
      8'h21: letter = 8'h63;
      8'h23: letter = 8'h64;
      8'h24: letter = 8'h65;
      8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67;
      8'h33: letter = 8'h68;
      8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A;
      8'h42: letter = 8'h6B;
      8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D;
      8'h31: letter = 8'h6E;
      8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70;
      8'h15: letter = 8'h71;
      8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73;
      8'h2C: letter = 8'h74;
      8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76;
      8'h1D: letter = 8'h77;
      8'h22: letter = 8'h78;
      8'h35: letter = 8'h79;
      8'h1A: letter = 8'h7A;
      8'h45: symbol = 8'h30;
      8'h16: symbol = 8'h31;
      8'h1E: symbol = 8'h32;
      8'h26: symbol = 8'h33;
      8'h25: symbol = 8'h34;
      8'h2E: symbol = 8'h35;
      8'h36: symbol = 8'h36;
      8'h3D: symbol = 8'h37;
      8'h3E: symbol = 8'h38;
      8'h46: symbol = 8'h39;
      8'h29: symbol = 8'h20;
      8'h5A: symbol = 8'h0D;
      8'h66: symbol = 8'h08;
      8'h0D: symbol = 8'h09;
      8'h76: symbol = 8'h1B;
      default: begin
        letter = 8'h00;
        symbol = 8'h00;
      end
    endcase
  end

  // Upper case differs from lower case only in bit 5.
  assign bus.ascii = (letter != 8'h00) ?
                     (bus.uppercase ? {letter[7:6], 1'b0, letter[4:0]} : letter) : symbol;

endmodule

// File: tb/tb_ps2_keyboard_ascii.sv
// Directed self-checking bench for ps2_keyboard_ascii: frames, FIFO, overflow, parity, reset.
module tb_ps2_keyboard_ascii;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ps2_keyboard_ascii_if bus ();

  ps2_keyboard_ascii dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (5) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (5) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_parity);
    logic [10:0] frame;
    frame = {1'b1, (~^code) ^ bad_parity, code, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(frame[i]);
    ps2_data = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic pop;
    @(posedge clk);
    #1 bus.nextdata_n = 1'b0;
    @(posedge clk);
    #1 bus.nextdata_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0", bus.ready);
    end
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_overflow: got %b want 0", bus.overflow);
    end
  endtask

  task automatic test_letter;
    bus.uppercase = 1'b0;
    send_frame(8'h1C, 1'b0);
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL letter_ready: got %b want 1", bus.ready);
    end
    checks++;
    if (bus.data !== 8'h1C) begin
      errors++;
      $display("FAIL letter_data: got %h want 1c", bus.data);
    end
    checks++;
    if (bus.ascii !== 8'h61) begin
      errors++;
      $display("FAIL letter_lower: got %h want 61", bus.ascii);
    end
    bus.uppercase = 1'b1;
    #1;
    checks++;
    if (bus.ascii !== 8'h41) begin
      errors++;
      $display("FAIL letter_upper: got %h want 41", bus.ascii);
    end
    bus.uppercase = 1'b0;
    pop();
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL letter_pop_ready: got %b want 0", bus.ready);
    end
  endtask

  task automatic test_break_make;
    send_frame(8'hF0, 1'b0);
    checks++;
    if (bus.data !== 8'hF0) begin
      errors++;
      $display("FAIL break_data: got %h want f0", bus.data);
    end
    checks++;
    if (bus.ascii !== 8'h00) begin
      errors++;
      $display("FAIL break_ascii: got %h want 00", bus.ascii);
    end
    pop();
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL break_pop_ready: got %b want 0", bus.ready);
    end
    send_frame(8'h1C, 1'b0);
    checks++;
    if (bus.data !== 8'h1C || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL make_data: got %h/%b want 1c/1", bus.data, bus.ready);
    end
    pop();
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL make_pop_ready: got %b want 0", bus.ready);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] codes [9];
    logic [7:0] exp_ascii [8];
    codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    exp_ascii = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68};
    for (int i = 0; i < 8; i++) send_frame(codes[i], 1'b0);
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_at_full: got %b want 0", bus.overflow);
    end
    send_frame(codes[8], 1'b0);
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got %b want 1", bus.overflow);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.data !== codes[i]) begin
        errors++;
        $display("FAIL ovf_data[%0d]: got %h want %h", i, bus.data, codes[i]);
      end
      checks++;
      if (bus.ascii !== exp_ascii[i]) begin
        errors++;
        $display("FAIL ovf_ascii[%0d]: got %h want %h", i, bus.ascii, exp_ascii[i]);
      end
      pop();
    end
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL ovf_ninth_lost: ready %b want 0", bus.ready);
    end
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b want 1", bus.overflow);
    end
    do_reset();
  endtask

  task automatic test_parity;
    send_frame(8'h16, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL parity_reject: ready %b want 0", bus.ready);
    end
`else
    checks++;
    if (bus.ready !== 1'b1 || bus.data !== 8'h16) begin
      errors++;
      $display("FAIL parity_ignore: got %b/%h want 1/16", bus.ready, bus.data);
    end
    checks++;
    if (bus.ascii !== 8'h31) begin
      errors++;
      $display("FAIL parity_ascii: got %h want 31", bus.ascii);
    end
    pop();
`endif
  endtask

  task automatic test_reset_mid_frame;
    // Start bit plus four data bits of 0x5A, then reset.
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    do_reset();
    send_frame(8'h29, 1'b0);
    checks++;
    if (bus.ready !== 1'b1 || bus.data !== 8'h29) begin
      errors++;
      $display("FAIL midrst_data: got %b/%h want 1/29", bus.ready, bus.data);
    end
    checks++;
    if (bus.ascii !== 8'h20) begin
      errors++;
      $display("FAIL midrst_ascii: got %h want 20", bus.ascii);
    end
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL midrst_overflow: got %b want 0", bus.overflow);
    end
    pop();
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_single: ready %b want 0", bus.ready);
    end
  endtask

  task automatic test_symbols;
    logic [7:0] codes [4];
    logic [7:0] exp_ascii [4];
    codes = '{8'h45, 8'h5A, 8'hE0, 8'h76};
    exp_ascii = '{8'h30, 8'h0D, 8'h00, 8'h1B};
    bus.uppercase = 1'b1;
    for (int i = 0; i < 4; i++) send_frame(codes[i], 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.data !== codes[i] || bus.ascii !== exp_ascii[i]) begin
        errors++;
        $display("FAIL sym[%0d]: got %h/%h want %h/%h", i, bus.data, bus.ascii,
                 codes[i], exp_ascii[i]);
      end
      pop();
    end
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL sym_empty: ready %b want 0", bus.ready);
    end
    bus.uppercase = 1'b0;
  endtask

  initial begin
    bus.nextdata_n = 1'b1;
    bus.uppercase  = 1'b0;
    test_reset();
    test_letter();
    test_break_make();
    test_overflow();
    test_parity();
    test_reset_mid_frame();
    test_symbols();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
